// File: rtl/regfile_sched_pkg.sv
// rtl/regfile_sched_pkg.sv - shared widths and FSM state for the register-file port scheduler
//
// Purpose : default warp/register index widths and the scheduler state encoding.
// Contents: WARP_W, ADDR_W (default geometry), sched_state_e {ST_INIT, ST_RUN}.

package regfile_sched_pkg;

    localparam int WARP_W = $clog2(8);
    localparam int ADDR_W = $clog2(32);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant over N requesters
//
// Purpose : picks the first requester that is also eligible, searching upward
//           from ptr_i and wrapping at N-1.
// Ports   : req_i    [N]  request vector
//           elig_i   [N]  eligibility mask (ANDed with req_i)
//           ptr_i    [PW] search start index
//           grant_o  [N]  one-hot grant, zero when no eligible request

module rr_arbiter #(
    parameter  int N  = 8,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  elig_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [N-1:0]  cand;
    logic [PW-1:0] idx;
    logic          found;

    assign cand = req_i & elig_i;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && cand[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_port_scheduler.sv
// rtl/regfile_port_scheduler.sv - clears and then arbitrates the ports of a per-warp register block
//
// Purpose : after reset, sweeps every {warp,reg} writing zero on all lanes; then
//           each cycle accepts writeback (priority) plus at most one warp's
//           two-operand read. All register_block inputs come from flops.
// Ports   : clk, rst                      clock, synchronous active-high reset
//           rd_req_valid/ready [NUM_WARPS] per-warp read request / one-hot grant
//           rd_req_src0/src1/mask         packed per-warp operands and lane mask
//           wb_valid/ready, wb_warp, wb_addr, wb_mask, wb_data   writeback request
//           rb_*                          register_block controls and write data
//           rsp_valid, rsp_warp           rdata valid this cycle and its owner
//           init_done                     clear sweep finished (sticky)

module regfile_port_scheduler
    import regfile_sched_pkg::*;
#(
    parameter  int NUM_WARPS = 1 << WARP_W,
    parameter  int NUM_LANES = 8,
    parameter  int NUM_REGS  = 1 << ADDR_W,
    parameter  int DATA_W    = 64,
    localparam int WB        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int AB        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WARPS-1:0]        rd_req_valid,
    output logic [NUM_WARPS-1:0]        rd_req_ready,
    input  logic [NUM_WARPS*AB-1:0]     rd_req_src0,
    input  logic [NUM_WARPS*AB-1:0]     rd_req_src1,
    input  logic [NUM_WARPS*NUM_LANES-1:0] rd_req_mask,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [WB-1:0]               wb_warp,
    input  logic [AB-1:0]               wb_addr,
    input  logic [NUM_LANES-1:0]        wb_mask,
    input  logic [NUM_LANES*DATA_W-1:0] wb_data,
    output logic [WB-1:0]               rb_warp_selector,
    output logic [NUM_LANES-1:0]        rb_read_en_0,
    output logic [NUM_LANES-1:0]        rb_read_en_1,
    output logic [AB-1:0]               rb_raddr_0,
    output logic [AB-1:0]               rb_raddr_1,
    output logic [NUM_LANES-1:0]        rb_write_en,
    output logic [AB-1:0]               rb_waddr,
    output logic [NUM_LANES*DATA_W-1:0] rb_wdata,
    output logic                        rsp_valid,
    output logic [WB-1:0]               rsp_warp,
    output logic                        init_done
);

    localparam logic [WB-1:0] LAST_WARP = WB'(NUM_WARPS - 1);
    localparam logic [AB-1:0] LAST_REG  = AB'(NUM_REGS - 1);

    sched_state_e                state_q;
    logic [WB-1:0]               init_warp_q;
    logic [AB-1:0]               init_reg_q;
    logic [WB-1:0]               rr_ptr_q, rr_ptr_d;

    logic [WB-1:0]               warp_sel_q;
    logic [NUM_LANES-1:0]        rd_en0_q, rd_en1_q, wr_en_q;
    logic [AB-1:0]               raddr0_q, raddr1_q, waddr_q;
    logic [NUM_LANES*DATA_W-1:0] wdata_q;
    logic                        rsp_valid_q, init_done_q;
    logic [WB-1:0]               rsp_warp_q;

    logic                        running;
    logic [AB-1:0]               wb_src0, wb_src1;
    logic                        hazard;
    logic [NUM_WARPS-1:0]        elig, grant;
    logic [WB-1:0]               gnt_idx;
    logic                        rd_fire;
    logic [AB-1:0]               gnt_src0, gnt_src1;
    logic [NUM_LANES-1:0]        gnt_mask;

    assign running  = (state_q == ST_RUN);
    assign wb_ready = running;

    // A read of the register being written this cycle would see stale data,
    // since the write only lands one cycle after the read is issued.
    assign wb_src0 = rd_req_src0[wb_warp*AB +: AB];
    assign wb_src1 = rd_req_src1[wb_warp*AB +: AB];
    assign hazard  = (wb_src0 == wb_addr) || (wb_src1 == wb_addr);

    // Writeback shares the single warp selector, so under wb_valid only the
    // writeback's own warp can read alongside it.
    always_comb begin
        elig = '0;
        if (running) begin
            if (wb_valid) begin
                if (!hazard) elig[wb_warp] = 1'b1;
            end else begin
                elig = '1;
            end
        end
    end

    rr_arbiter #(.N(NUM_WARPS)) u_rr_arbiter (
        .req_i   (rd_req_valid),
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    assign rd_req_ready = grant;
    assign rd_fire      = |grant;

    always_comb begin
        gnt_idx = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (grant[w]) gnt_idx = WB'(w);
        end
    end

    assign gnt_src0 = rd_req_src0[gnt_idx*AB +: AB];
    assign gnt_src1 = rd_req_src1[gnt_idx*AB +: AB];
    assign gnt_mask = rd_req_mask[gnt_idx*NUM_LANES +: NUM_LANES];

    // Pointer only advances on a genuine round-robin decision.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rd_fire && !wb_valid) begin
            rr_ptr_d = (gnt_idx == LAST_WARP) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_warp_q <= '0;
            init_reg_q  <= '0;
            rr_ptr_q    <= '0;
            warp_sel_q  <= '0;
            rd_en0_q    <= '0;
            rd_en1_q    <= '0;
            wr_en_q     <= '0;
            raddr0_q    <= '0;
            raddr1_q    <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_warp_q  <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == ST_INIT) begin
            warp_sel_q  <= init_warp_q;
            waddr_q     <= init_reg_q;
            wr_en_q     <= '1;
            wdata_q     <= '0;
            rd_en0_q    <= '0;
            rd_en1_q    <= '0;
            rsp_valid_q <= 1'b0;
            if (init_reg_q == LAST_REG) begin
                init_reg_q <= '0;
                if (init_warp_q == LAST_WARP) begin
                    state_q     <= ST_RUN;
                    init_done_q <= 1'b1;
                end else begin
                    init_warp_q <= init_warp_q + 1'b1;
                end
            end else begin
                init_reg_q <= init_reg_q + 1'b1;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wb_valid ? wb_mask : '0;
            if (wb_valid) begin
                waddr_q    <= wb_addr;
                wdata_q    <= wb_data;
                warp_sel_q <= wb_warp;
            end
            if (rd_fire) begin
                rd_en0_q    <= gnt_mask;
                rd_en1_q    <= gnt_mask;
                raddr0_q    <= gnt_src0;
                raddr1_q    <= gnt_src1;
                warp_sel_q  <= gnt_idx;
                rsp_valid_q <= 1'b1;
                rsp_warp_q  <= gnt_idx;
            end else begin
                rd_en0_q    <= '0;
                rd_en1_q    <= '0;
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rb_warp_selector = warp_sel_q;
    assign rb_read_en_0     = rd_en0_q;
    assign rb_read_en_1     = rd_en1_q;
    assign rb_raddr_0       = raddr0_q;
    assign rb_raddr_1       = raddr1_q;
    assign rb_write_en      = wr_en_q;
    assign rb_waddr         = waddr_q;
    assign rb_wdata         = wdata_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_warp         = rsp_warp_q;
    assign init_done        = init_done_q;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// tb/tb_regfile_port_scheduler.sv - self-checking bench for regfile_port_scheduler

module tb_regfile_port_scheduler;

    localparam int NW = 8;
    localparam int NL = 8;
    localparam int NR = 32;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     rd_req_valid;
    logic [NW-1:0]     rd_req_ready;
    logic [NW*5-1:0]   rd_req_src0;
    logic [NW*5-1:0]   rd_req_src1;
    logic [NW*NL-1:0]  rd_req_mask;
    logic              wb_valid;
    logic              wb_ready;
    logic [2:0]        wb_warp;
    logic [4:0]        wb_addr;
    logic [NL-1:0]     wb_mask;
    logic [NL*DW-1:0]  wb_data;
    logic [2:0]        rb_warp_selector;
    logic [NL-1:0]     rb_read_en_0, rb_read_en_1, rb_write_en;
    logic [4:0]        rb_raddr_0, rb_raddr_1, rb_waddr;
    logic [NL*DW-1:0]  rb_wdata;
    logic              rsp_valid;
    logic [2:0]        rsp_warp;
    logic              init_done;

    always #5 clk = ~clk;

    regfile_port_scheduler #(
        .NUM_WARPS(NW), .NUM_LANES(NL), .NUM_REGS(NR), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_src0(rd_req_src0), .rd_req_src1(rd_req_src1), .rd_req_mask(rd_req_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_addr(wb_addr),
        .wb_mask(wb_mask), .wb_data(wb_data),
        .rb_warp_selector(rb_warp_selector), .rb_read_en_0(rb_read_en_0), .rb_read_en_1(rb_read_en_1),
        .rb_raddr_0(rb_raddr_0), .rb_raddr_1(rb_raddr_1), .rb_write_en(rb_write_en),
        .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
        .rsp_valid(rsp_valid), .rsp_warp(rsp_warp), .init_done(init_done)
    );

    // register_block environment: lane-masked write at the clock edge, combinational read
    logic [DW-1:0]    rf [NW][NR][NL];
    logic [NL*DW-1:0] rdata_0, rdata_1;

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (rb_write_en[l]) rf[rb_warp_selector][rb_waddr][l] <= rb_wdata[l*DW +: DW];
        end
    end

    always_comb begin
        rdata_0 = '0;
        rdata_1 = '0;
        for (int l = 0; l < NL; l++) begin
            if (rb_read_en_0[l]) rdata_0[l*DW +: DW] = rf[rb_warp_selector][rb_raddr_0][l];
            if (rb_read_en_1[l]) rdata_1[l*DW +: DW] = rf[rb_warp_selector][rb_raddr_1][l];
        end
    end

    // reference contents, all zero once the clear sweep is done
    logic [NL*DW-1:0] ref_rf [NW][NR];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rdv;
        logic       wbv;
        logic [2:0] wbw;
        logic [4:0] wba;
        logic [7:0] exp_gnt;
    } vec_t;

    typedef struct {
        logic             rv;
        logic [2:0]       rw;
        logic [7:0]       ren;
        logic [4:0]       ra0;
        logic [4:0]       ra1;
        logic             wv;
        logic [7:0]       wen;
        logic [2:0]       ww;
        logic [4:0]       wa;
        logic [NL*DW-1:0] wd;
    } exp_t;

    typedef struct {
        logic [2:0]       w;
        logic [NL*DW-1:0] d0;
        logic [NL*DW-1:0] d1;
    } rsp_t;

    vec_t tbl [16];
    exp_t exp_q [$];
    rsp_t rsp_q [$];

    task automatic chk(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int oh2i(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void ref_write(input int w, input int a, input logic [NL-1:0] m,
                                      input logic [NL*DW-1:0] d);
        for (int l = 0; l < NL; l++) begin
            if (m[l]) ref_rf[w][a][l*DW +: DW] = d[l*DW +: DW];
        end
    endfunction

    // per-warp operands: src0=w+5, src1=w+7, mask clears lane w; warp 5 has a zero mask
    task automatic set_pattern();
        logic [7:0] m;
        for (int w = 0; w < NW; w++) begin
            rd_req_src0[w*5 +: 5] = 5'(w + 5);
            rd_req_src1[w*5 +: 5] = 5'(w + 7);
            m = 8'h01 << w;
            rd_req_mask[w*NL +: NL] = (w == 5) ? 8'h00 : ~m;
        end
    endtask

    // one clear-sweep step k (1-based count of edges since rst fell)
    task automatic init_step(input int k, input int total);
        logic [42:0] act, expv;
        int          s;
        logic        fin;
        @(posedge clk);
        fin = (k == total) && (total == NW*NR);
        if (fin) begin
            #1;
            rd_req_valid = '0;
            wb_valid     = 1'b0;
        end
        @(negedge clk);
        s    = k - 1;
        act  = {init_done, wb_ready, rd_req_ready, rsp_valid, rb_read_en_0, rb_read_en_1,
                rb_write_en, rb_warp_selector, rb_waddr};
        expv = {fin, fin, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 3'(s / NR), 5'(s % NR)};
        chk($sformatf("init_step_%0d", k), act, expv);
    endtask

    task automatic check_cycle(input int i);
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk($sformatf("rsp_valid_r%0d", i), rsp_valid, e.rv);
        chk($sformatf("write_en_r%0d", i), rb_write_en, e.wen);
        if (e.rv) begin
            chk($sformatf("rsp_warp_r%0d", i), rsp_warp, e.rw);
            chk($sformatf("read_en_0_r%0d", i), rb_read_en_0, e.ren);
            chk($sformatf("read_en_1_r%0d", i), rb_read_en_1, e.ren);
            chk($sformatf("raddr_0_r%0d", i), rb_raddr_0, e.ra0);
            chk($sformatf("raddr_1_r%0d", i), rb_raddr_1, e.ra1);
            chk($sformatf("selector_r%0d", i), rb_warp_selector, e.rw);
        end
        if (e.wv) begin
            chk($sformatf("waddr_r%0d", i), rb_waddr, e.wa);
            chk($sformatf("wdata_r%0d", i), rb_wdata, e.wd);
            if (!e.rv) chk($sformatf("wsel_r%0d", i), rb_warp_selector, e.ww);
        end
    endtask

    // waits a bounded number of cycles for rsp_valid, then compares against the scoreboard
    task automatic wait_rsp(input string nm);
        rsp_t r;
        logic got = 1'b0;
        for (int t = 0; t < 4 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk({nm, "_rsp_seen"}, got, 1'b1);
        if (got && rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            chk({nm, "_rsp_warp"}, rsp_warp, r.w);
            chk({nm, "_rdata_0"}, rdata_0, r.d0);
            chk({nm, "_rdata_1"}, rdata_1, r.d1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int w, input int a, input logic [NL-1:0] m, input logic [NL*DW-1:0] d);
        wb_valid = 1'b1;
        wb_warp  = 3'(w);
        wb_addr  = 5'(a);
        wb_mask  = m;
        wb_data  = d;
        @(negedge clk);
        chk("sweep_wb_ready", wb_ready, 1'b1);
        ref_write(w, a, m, d);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic do_read(input int w, input int s0, input int s1);
        rsp_t r;
        logic [7:0] onehot;
        onehot = 8'h01 << w;
        rd_req_src0[w*5 +: 5]   = 5'(s0);
        rd_req_src1[w*5 +: 5]   = 5'(s1);
        rd_req_mask[w*NL +: NL] = 8'hFF;
        rd_req_valid            = onehot;
        @(negedge clk);
        chk("sweep_grant", rd_req_ready, onehot);
        r.w  = 3'(w);
        r.d0 = ref_rf[w][s0];
        r.d1 = ref_rf[w][s1];
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        rd_req_valid = '0;
        wait_rsp("sweep");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t             e;
        rsp_t             r;
        logic [DW-1:0]    dv;
        logic [NL*DW-1:0] d;
        int               gw;

        //          rdv    wbv   wbw   wba    exp_gnt
        tbl[0]  = '{8'h00, 1'b0, 3'd0, 5'd0,  8'h00};
        tbl[1]  = '{8'h4A, 1'b0, 3'd0, 5'd0,  8'h02};
        tbl[2]  = '{8'h4A, 1'b0, 3'd0, 5'd0,  8'h08};
        tbl[3]  = '{8'h4A, 1'b0, 3'd0, 5'd0,  8'h40};
        tbl[4]  = '{8'h4A, 1'b0, 3'd0, 5'd0,  8'h02};
        tbl[5]  = '{8'h14, 1'b1, 3'd2, 5'd5,  8'h04};
        tbl[6]  = '{8'h10, 1'b0, 3'd0, 5'd0,  8'h10};
        tbl[7]  = '{8'h01, 1'b1, 3'd0, 5'd5,  8'h00};
        tbl[8]  = '{8'h01, 1'b0, 3'd0, 5'd0,  8'h01};
        tbl[9]  = '{8'h02, 1'b1, 3'd3, 5'd0,  8'h00};
        tbl[10] = '{8'hFF, 1'b0, 3'd0, 5'd0,  8'h02};
        tbl[11] = '{8'hFF, 1'b1, 3'd7, 5'd0,  8'h80};
        tbl[12] = '{8'hFF, 1'b0, 3'd0, 5'd0,  8'h04};
        tbl[13] = '{8'h08, 1'b1, 3'd3, 5'd10, 8'h00};
        tbl[14] = '{8'h20, 1'b0, 3'd0, 5'd0,  8'h20};
        tbl[15] = '{8'h41, 1'b0, 3'd0, 5'd0,  8'h40};

        for (int w = 0; w < NW; w++)
            for (int a = 0; a < NR; a++) ref_rf[w][a] = '0;

        // reset with requests pending: nothing may be granted
        rst          = 1'b1;
        rd_req_valid = '1;
        wb_valid     = 1'b1;
        wb_warp      = '0;
        wb_addr      = '0;
        wb_mask      = '1;
        wb_data      = '0;
        set_pattern();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {init_done, rsp_valid, rb_write_en, rb_read_en_0, rb_warp_selector, rb_waddr},
            {1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'd0});
        chk("reset_ready", {wb_ready, rd_req_ready}, 9'd0);
        rst = 1'b0;

        // partial sweep, then reset at counter 100
        for (int k = 1; k <= 100; k++) init_step(k, 100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midinit_reset", {init_done, rb_write_en, rb_warp_selector, rb_waddr}, {1'b0, 8'h00, 3'd0, 5'd0});
        rst = 1'b0;
        for (int k = 1; k <= NW*NR; k++) init_step(k, NW*NR);

        // arbitration table
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            dv           = 64'h1111_0000_0000_0000 | 64'(i);
            d            = {NL{dv}};
            rd_req_valid = tbl[i].rdv;
            wb_valid     = tbl[i].wbv;
            wb_warp      = tbl[i].wbw;
            wb_addr      = tbl[i].wba;
            wb_mask      = 8'hA5;
            wb_data      = d;
            @(negedge clk);
            check_cycle(i);
            chk($sformatf("grant_r%0d", i), rd_req_ready, tbl[i].exp_gnt);
            chk($sformatf("wb_ready_r%0d", i), wb_ready, 1'b1);
            gw    = oh2i(tbl[i].exp_gnt);
            e.rv  = |tbl[i].exp_gnt;
            e.rw  = 3'(gw);
            e.ren = rd_req_mask[gw*NL +: NL];
            e.ra0 = rd_req_src0[gw*5 +: 5];
            e.ra1 = rd_req_src1[gw*5 +: 5];
            e.wv  = tbl[i].wbv;
            e.wen = tbl[i].wbv ? 8'hA5 : 8'h00;
            e.ww  = tbl[i].wbw;
            e.wa  = tbl[i].wba;
            e.wd  = d;
            exp_q.push_back(e);
            if (tbl[i].wbv) ref_write(int'(tbl[i].wbw), int'(tbl[i].wba), 8'hA5, d);
            @(posedge clk);
            #1;
        end
        rd_req_valid = '0;
        wb_valid     = 1'b0;
        @(negedge clk);
        check_cycle(16);
        @(posedge clk);
        #1;

        // hazard: write warp0 reg3 while warp0 reads it
        dv                  = 64'h0000_0000_DEAD_BEEF;
        d                   = {NL{dv}};
        rd_req_src0[0 +: 5] = 5'd3;
        rd_req_src1[0 +: 5] = 5'd4;
        rd_req_mask[0 +: 8] = 8'hFF;
        rd_req_valid        = 8'h01;
        wb_valid            = 1'b1;
        wb_warp             = 3'd0;
        wb_addr             = 5'd3;
        wb_mask             = 8'hFF;
        wb_data             = d;
        @(negedge clk);
        chk("haz_stall", rd_req_ready, 8'h00);
        chk("haz_wb_ready", wb_ready, 1'b1);
        ref_write(0, 3, 8'hFF, d);
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("haz_grant_after_stall", rd_req_ready, 8'h01);
        r.w  = 3'd0;
        r.d0 = d;
        r.d1 = ref_rf[0][4];
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        rd_req_valid = '0;
        wait_rsp("haz");

        // full sweep: random lane-masked writes, each followed by a read
        for (int rep = 0; rep < 10; rep++) begin
            for (int w = 0; w < NW; w++) begin
                for (int a = 0; a < NR; a++) begin
                    for (int k = 0; k < NL*DW/32; k++) d[k*32 +: 32] = $urandom;
                    do_write(w, a, 8'($urandom_range(0, 255)), d);
                    do_read(w, a, $urandom_range(0, NR-1));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
